// File: rtl/hilo_div_unit.sv
// HI/LO register pair with an iterative restoring divider for MIPS DIV/DIVU.
// Direct HI/LO writes are accepted in any state; a division result written in FIX takes priority.
module hilo_div_unit #(
  parameter int unsigned DIV_ITER = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_div_start,
  input  logic        i_div_signed,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  input  logic        i_div_cancel,
  input  logic        i_hi_we,
  input  logic        i_lo_we,
  input  logic [31:0] i_hi_wdata,
  input  logic [31:0] i_lo_wdata,
  output logic        o_busy,
  output logic        o_div_done,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam int unsigned CW = $clog2(DIV_ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     quo_q, quo_d;
  logic [31:0]     dvs_q, dvs_d;
  logic [32:0]     rem_q, rem_d;
  logic [31:0]     raw_q, raw_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            dbz_q, dbz_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic            done_q, done_d;

  // 34-bit trial so the borrow of the shifted 33-bit remainder is visible in bit 33
  logic [33:0]     shifted;
  logic [33:0]     trial;

  always_comb begin
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {2'b00, dvs_q};
  end

  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    raw_d   = raw_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    hi_d    = i_hi_we ? i_hi_wdata : hi_q;
    lo_d    = i_lo_we ? i_lo_wdata : lo_q;

    unique case (state_q)
      IDLE: begin
        if (i_div_start && !i_div_cancel) begin
          quo_d   = (i_div_signed && i_dividend[31]) ? (32'd0 - i_dividend) : i_dividend;
          dvs_d   = (i_div_signed && i_divisor[31])  ? (32'd0 - i_divisor)  : i_divisor;
          qneg_d  = i_div_signed & (i_dividend[31] ^ i_divisor[31]);
          rneg_d  = i_div_signed & i_dividend[31];
          raw_d   = i_dividend;
          rem_d   = '0;
          cnt_d   = '0;
          dbz_d   = (i_divisor == '0);
          state_d = (i_divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        if (i_div_cancel) begin
          state_d = IDLE;
        end else begin
          if (!trial[33]) begin
            rem_d = trial[32:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = shifted[32:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DIV_ITER - 1)) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!i_div_cancel) begin
          done_d = 1'b1;
          if (dbz_q) begin
            lo_d = '1;
            hi_d = raw_q;
          end else begin
            lo_d = qneg_q ? (32'd0 - quo_q) : quo_q;
            hi_d = rneg_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      raw_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      raw_q   <= raw_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign o_busy     = (state_q != IDLE);
  assign o_div_done = done_q;
  assign o_hi       = hi_q;
  assign o_lo       = lo_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Scoreboard bench for hilo_div_unit: expected HI/LO queued at start, checked on each done pulse.
module tb_hilo_div_unit;

  logic        clk;
  logic        rst_n;
  logic        div_start;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        div_cancel;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic        busy;
  logic        div_done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          total;
  int          bad;
  int          done_cnt;
  logic [63:0] exp_q[$];

  hilo_div_unit #(.DIV_ITER(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_div_start  (div_start),
    .i_div_signed (div_signed),
    .i_dividend   (dividend),
    .i_divisor    (divisor),
    .i_div_cancel (div_cancel),
    .i_hi_we      (hi_we),
    .i_lo_we      (lo_we),
    .i_hi_wdata   (hi_wdata),
    .i_lo_wdata   (lo_wdata),
    .o_busy       (busy),
    .o_div_done   (div_done),
    .o_hi         (hi),
    .o_lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && div_done) begin
      done_cnt = done_cnt + 1;
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_done: hi=%h lo=%h with empty scoreboard", hi, lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({hi, lo} !== e) begin
          bad = bad + 1;
          $display("FAIL div_result: got hi=%h lo=%h, want hi=%h lo=%h", hi, lo, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input int ebusy, input bit inject, input string nm);
    int n;
    int d0;
    exp_q.push_back({ehi, elo});
    d0 = done_cnt;
    @(posedge clk); #1;
    div_start = 1'b1; div_signed = sg; dividend = a; divisor = b;
    @(posedge clk); #1;
    div_start = 1'b0; dividend = 32'h0; divisor = 32'h0;
    n = 0;
    while (busy && n < 100) begin
      if (inject && n == 5) begin
        div_start = 1'b1; div_signed = 1'b0; dividend = 32'd9; divisor = 32'd3;
      end else begin
        div_start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    div_start = 1'b0;
    total++;
    if (n !== ebusy) begin
      bad++;
      $display("FAIL %s_busy_cycles: got %0d, want %0d", nm, n, ebusy);
    end
    @(negedge clk); @(negedge clk);
    total++;
    if (done_cnt !== d0 + 1) begin
      bad++;
      $display("FAIL %s_done_pulses: got %0d, want 1", nm, done_cnt - d0);
    end
    total++;
    if (div_done !== 1'b0) begin
      bad++;
      $display("FAIL %s_done_width: done=%b, want 0", nm, div_done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, want 0", busy); end
    total++;
    if (div_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b, want 0", div_done); end
    total++;
    if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL reset_hilo: got %h_%h, want 0_0", hi, lo); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    run_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0, "divu_100_7");
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF, 33, 1'b0, "divu_max_1");
  endtask

  task automatic test_signed();
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0, "div_m7_2");
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33, 1'b0, "div_7_m2");
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, 1'b0, "div_ovf");
  endtask

  task automatic test_div_zero();
    run_div(1'b0, 32'd1234, 32'd0, 32'd1234, 32'hFFFFFFFF, 1, 1'b0, "divu_zero");
    run_div(1'b1, 32'hFFFFFF00, 32'd0, 32'hFFFFFF00, 32'hFFFFFFFF, 1, 1'b0, "div_zero");
  endtask

  task automatic test_start_while_busy();
    run_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b1, "start_busy");
  endtask

  task automatic test_direct_cancel();
    int d0;
    @(posedge clk); #1;
    hi_we = 1'b1; lo_we = 1'b1; hi_wdata = 32'hAAAA0000; lo_wdata = 32'h00005555;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    total++;
    if ({hi, lo} !== {32'hAAAA0000, 32'h00005555}) begin
      bad++; $display("FAIL direct_write: got %h_%h, want aaaa0000_00005555", hi, lo);
    end
    d0 = done_cnt;
    div_start = 1'b1; div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    div_cancel = 1'b1;
    @(posedge clk); #1;
    div_cancel = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL cancel_busy: got %b, want 0", busy); end
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (done_cnt !== d0) begin bad++; $display("FAIL cancel_done: got %0d pulses, want 0", done_cnt - d0); end
    total++;
    if ({hi, lo} !== {32'hAAAA0000, 32'h00005555}) begin
      bad++; $display("FAIL cancel_hilo: got %h_%h, want aaaa0000_00005555", hi, lo);
    end
  endtask

  task automatic test_fix_wins();
    exp_q.push_back({32'd2, 32'd14});
    @(posedge clk); #1;
    div_start = 1'b1; div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (32) begin @(posedge clk); #1; end
    lo_we = 1'b1; lo_wdata = 32'h0000DEAD;
    @(posedge clk); #1;
    lo_we = 1'b0;
    total++;
    if (lo !== 32'd14) begin bad++; $display("FAIL fix_wins_lo: got %h, want 0000000e", lo); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_cnt;
    @(posedge clk); #1;
    div_start = 1'b1; div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b, want 0", busy); end
    total++;
    if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL rst_mid_hilo: got %h_%h, want 0_0", hi, lo); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (done_cnt !== d0 || {hi, lo} !== 64'h0) begin
      bad++; $display("FAIL rst_mid_discard: pulses=%0d hi=%h lo=%h, want 0 pulses and 0", done_cnt - d0, hi, lo);
    end
  endtask

  initial begin
    total = 0; bad = 0; done_cnt = 0;
    div_start = 1'b0; div_signed = 1'b0; dividend = '0; divisor = '0;
    div_cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; hi_wdata = '0; lo_wdata = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_start_while_busy();
    test_direct_cancel();
    test_fix_wins();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: %0d results never produced, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
